// File: rtl/axi_hdr_pkg.sv
// axi_hdr_pkg: shared state type, default widths and round-robin pick helper for the header arbiter
package axi_hdr_pkg;
    localparam int DATA_WD = 32;
    localparam int DATA_BYTE_WD = DATA_WD / 8;
    localparam int BYTE_CNT_WD = $clog2(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_EOP} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scans downward so the smallest offset from ptr is the one that sticks.
    function automatic pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
        pick_t p;
        int k;
        p = '0;
        for (int i = 15; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= n) k = k - n;
            if (i < n && req[k[3:0]]) begin
                p.found = 1'b1;
                p.idx = k[3:0];
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: combinational round-robin picker over NUM_SRC requests starting at ptr
module rr_arbiter_core #(
    parameter int NUM_SRC = 4,
    parameter int SRC_ID_WD = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_ID_WD-1:0] ptr,
    output logic                 found,
    output logic [SRC_ID_WD-1:0] grant
);
    import axi_hdr_pkg::pick_t;
    import axi_hdr_pkg::rr_pick;

    pick_t pick;

    // first requester at or after ptr, wrapping modulo NUM_SRC
    always_comb pick = rr_pick(16'(req), 4'(ptr), NUM_SRC);

    assign found = pick.found;
    assign grant = SRC_ID_WD'(pick.idx);
endmodule

// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin owner of the inserter header port, one grant per packet, watchdog release
module axi_stream_header_arbiter #(
    parameter int DATA_WD = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC = 4,
    parameter int SRC_ID_WD = $clog2(NUM_SRC),
    parameter int WDOG_CYC = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              hdr_valid,
    input  logic [NUM_SRC*DATA_WD-1:0]      hdr_data,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] hdr_keep,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  hdr_byte_cnt,
    output logic [NUM_SRC-1:0]              hdr_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            mon_valid,
    input  logic                            mon_ready,
    input  logic                            mon_last,
    output logic [SRC_ID_WD-1:0]            grant_id,
    output logic                            busy,
    output logic                            wdog_timeout,
    output logic [15:0]                     pkt_cnt
);
    import axi_hdr_pkg::state_t;
    import axi_hdr_pkg::IDLE;
    import axi_hdr_pkg::ISSUE;
    import axi_hdr_pkg::WAIT_EOP;

    state_t               state;
    logic [SRC_ID_WD-1:0] rr_ptr;
    logic [SRC_ID_WD-1:0] pick_id;
    logic [SRC_ID_WD-1:0] next_ptr;
    logic                 pick_found;
    logic                 eop;
    logic                 wdog_hit;
    logic [31:0]          wdog_cnt;

    rr_arbiter_core #(.NUM_SRC(NUM_SRC), .SRC_ID_WD(SRC_ID_WD)) u_core (
        .req  (hdr_valid),
        .ptr  (rr_ptr),
        .found(pick_found),
        .grant(pick_id)
    );

    // accept pulse to the winner in the same cycle it is picked; silent while in reset
    always_comb begin
        hdr_ready = (!rst && state == IDLE && pick_found) ? (NUM_SRC'(1) << pick_id) : '0;
        eop = mon_valid & mon_ready & mon_last;
        wdog_hit = (WDOG_CYC != 0) && (wdog_cnt == 32'(WDOG_CYC - 1));
        next_ptr = (grant_id == SRC_ID_WD'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
    end

    // grant/issue/wait-for-EOP sequencer with header registers, watchdog and packet counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_id <= '0;
            valid_insert <= 1'b0;
            data_insert <= '0;
            keep_insert <= '0;
            byte_insert_cnt <= '0;
            busy <= 1'b0;
            wdog_timeout <= 1'b0;
            wdog_cnt <= '0;
            pkt_cnt <= '0;
        end else begin
            wdog_timeout <= 1'b0;
            case (state)
                IDLE: if (pick_found) begin
                    data_insert <= hdr_data[pick_id*DATA_WD +: DATA_WD];
                    keep_insert <= hdr_keep[pick_id*DATA_BYTE_WD +: DATA_BYTE_WD];
                    byte_insert_cnt <= hdr_byte_cnt[pick_id*BYTE_CNT_WD +: BYTE_CNT_WD];
                    grant_id <= pick_id;
                    valid_insert <= 1'b1;
                    busy <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: if (ready_insert) begin
                    valid_insert <= 1'b0;
                    wdog_cnt <= '0;
                    state <= WAIT_EOP;
                end
                WAIT_EOP: if (eop) begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                    rr_ptr <= next_ptr;
                    busy <= 1'b0;
                    state <= IDLE;
                end else if (wdog_hit) begin
                    wdog_timeout <= 1'b1;
                    rr_ptr <= next_ptr;
                    busy <= 1'b0;
                    state <= IDLE;
                end else begin
                    wdog_cnt <= wdog_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
